gcd_requester: RTL and testbench
================================

# gcd_requester

Client-side controller for the team's start/done GCD engine. It accepts operand pairs on a valid/ready stream, drives the engine's operand and start inputs, and waits for the engine's done pulse. It then returns the result on a valid/ready output stream. It sits between the system datapath and a `gcd` engine instance of the same WIDTH, handles the divide-by-zero case locally, and guards against a hung engine with a timeout.

## Interface
- WIDTH, 32, operand/result width; must match the engine.
- TIMEOUT, 64, max cycles spent in WAIT before an error response; must be ≥ 2.
- clk  in  1  clock; all logic rising-edge.
- reset_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  upstream operand pair valid.
- in_ready  out  1  requester can accept a pair.
- in_a  in  WIDTH  operand a.
- in_b  in  WIDTH  operand b.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_result  out  WIDTH  GCD result.
- out_error  out  1  qualifies out_result; 1 = engine timeout, result forced to 0.
- gcd_a  out  WIDTH  to engine a_in, registered.
- gcd_b  out  WIDTH  to engine b_in, registered.
- gcd_start  out  1  to engine start, registered, one-cycle pulse.
- gcd_done  in  1  from engine done, one-cycle pulse.
- gcd_result  in  WIDTH  from engine result; valid only while gcd_done = 1.
- busy  out  1  high in every state except IDLE.

## Operation
- **States:** IDLE, ISSUE, WAIT, HOLD, DRAIN.
- **IDLE:** in_ready = 1. On in_valid & in_ready, register in_a/in_b into gcd_a/gcd_b.
  - If in_b == 0, go to HOLD with out_result = in_a, out_error = 0. The engine is never started (bypass). gcd(0,0) = 0.
  - Otherwise go to ISSUE.
- **ISSUE:** gcd_start = 1 for exactly this cycle. gcd_a/gcd_b are stable. Go to WAIT and clear the timeout counter.
- **WAIT:** The counter increments each cycle.
  - On gcd_done = 1, capture gcd_result into out_result, set out_error = 0, and go to HOLD.
  - If the counter reaches TIMEOUT without gcd_done, set out_result = 0, out_error = 1, and go to HOLD. A drain flag is set.
  - gcd_done in the same cycle the counter reaches TIMEOUT counts as success; done wins.
- **HOLD:** out_valid = 1. out_result and out_error are held stable until out_valid & out_ready.
  - On acceptance, go to DRAIN if the drain flag is set, otherwise go to IDLE.
- **DRAIN:** in_ready = 0. Wait for a late gcd_done, which is discarded, or for a further TIMEOUT cycles. Then clear the drain flag and go to IDLE.
- gcd_done outside WAIT/DRAIN is ignored.
- gcd_a/gcd_b change only on input acceptance in IDLE; they are held through ISSUE, WAIT, HOLD, and DRAIN.
- in_ready is 0 in all states except IDLE. There is no input buffering; one request is in flight at a time.
- Unknown state encodings recover to IDLE.

## Timing
- **Reset:** Asynchronous, effective immediately. State = IDLE, in_ready = 1, out_valid = 0, out_result = 0, out_error = 0, gcd_start = 0, gcd_a = 0, gcd_b = 0, busy = 0. Counter and drain flag are cleared.
- **Reset mid-operation:** Any in-flight request is dropped with no response. The engine shares reset_n, so both restart clean.
- **Engine path,** with accept in cycle 0:
  - ISSUE in cycle 1 (gcd_start high).
  - Engine RUNNING from cycle 2.
  - If gcd_done occurs in cycle N, out_valid = 1 from cycle N+1.
- **Bypass path:** accept in cycle 0, out_valid = 1 in cycle 1.
- **Minimum back-to-back:** HOLD accepted in cycle k gives IDLE in cycle k+1, where in_ready = 1 and the next accept can occur.
- **Timeout:** out_valid rises TIMEOUT+1 cycles after the ISSUE cycle.

## Structure
- Shared package `gcd_pkg`:
  - the requester state enum (3-bit, IDLE = 0);
  - a default width constant GCD_WIDTH = 32, used by both engine and requester instantiations.
- The timeout counter is $clog2(TIMEOUT+1) bits, implemented inline.
- No sub-module is required. The engine is instantiated beside this block by the integrating top, not inside it.

## Test plan
- **Basic GCD:** (48, 18) with a real `gcd` engine -> one gcd_start pulse, out_result = 6, out_error = 0, out_valid held until out_ready.
- **Bypass:** (35, 0) -> no gcd_start, out_valid in cycle 1, out_result = 35; (0, 0) -> out_result = 0.
- **Zero a through engine:** (0, 14) -> engine used, out_result = 14. Also (4294967295, 65535) -> out_result = 65535.
- **Backpressure:** out_ready low for 5 cycles after out_valid -> out_result/out_error stable, in_ready = 0 and in_valid ignored; accept -> in_ready = 1 the next cycle.
- **Timeout:** stub engine never asserts gcd_done, TIMEOUT = 8 -> out_error = 1, out_result = 0, out_valid 9 cycles after ISSUE. After acceptance, DRAIN holds in_ready = 0 for 8 cycles, or until a late gcd_done injected at cycle 3 of DRAIN, then IDLE.
- **Reset mid-WAIT:** assert reset_n = 0 during WAIT of (1071, 462) -> all outputs at reset values immediately, no response. A new request (1071, 462) after release -> out_result = 21.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD engine and its requester.
// Default width and requester state encoding.
package gcd_pkg;

    localparam int GCD_WIDTH = 32;

    typedef enum logic [2:0] {
        REQ_IDLE  = 3'd0,
        REQ_ISSUE = 3'd1,
        REQ_WAIT  = 3'd2,
        REQ_HOLD  = 3'd3,
        REQ_DRAIN = 3'd4
    } req_state_e;

endpackage

// File: rtl/gcd_requester_if.sv
// Operand and result valid/ready streams of the GCD requester.
// slave = the requester side, master = the upstream/downstream side.
interface gcd_requester_if #(
    parameter int WIDTH = gcd_pkg::GCD_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_error;

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_result,
        output out_error
    );

    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_result,
        input  out_error
    );

endinterface

// File: rtl/gcd_requester.sv
// Client-side controller for the start/done GCD engine.
// Bypasses b == 0 locally and times out a hung engine.
module gcd_requester
    import gcd_pkg::*;
#(
    parameter int WIDTH   = GCD_WIDTH,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    gcd_requester_if.slave   io,
    output logic [WIDTH-1:0] gcd_a,
    output logic [WIDTH-1:0] gcd_b,
    output logic             gcd_start,
    input  logic             gcd_done,
    input  logic [WIDTH-1:0] gcd_result,
    output logic             busy
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE  = REQ_IDLE;
    localparam logic [2:0] S_ISSUE = REQ_ISSUE;
    localparam logic [2:0] S_WAIT  = REQ_WAIT;
    localparam logic [2:0] S_HOLD  = REQ_HOLD;
    localparam logic [2:0] S_DRAIN = REQ_DRAIN;

    logic [2:0]       state;
    logic [CW-1:0]    cnt;
    logic             drain;
    logic [WIDTH-1:0] res_q;
    logic             err_q;

    assign io.in_ready   = (state == S_IDLE);
    assign io.out_valid  = (state == S_HOLD);
    assign io.out_result = res_q;
    assign io.out_error  = err_q;
    assign busy          = (state != S_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            drain     <= 1'b0;
            res_q     <= '0;
            err_q     <= 1'b0;
            gcd_a     <= '0;
            gcd_b     <= '0;
            gcd_start <= 1'b0;
        end else begin
            gcd_start <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (io.in_valid) begin
                        gcd_a <= io.in_a;
                        gcd_b <= io.in_b;
                        if (io.in_b == '0) begin
                            res_q <= io.in_a;
                            err_q <= 1'b0;
                            state <= S_HOLD;
                        end else begin
                            gcd_start <= 1'b1;
                            state     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                // done has priority over the timeout in the same cycle
                S_WAIT: begin
                    if (gcd_done) begin
                        res_q <= gcd_result;
                        err_q <= 1'b0;
                        state <= S_HOLD;
                    end else if (cnt == CNT_LAST) begin
                        res_q <= '0;
                        err_q <= 1'b1;
                        drain <= 1'b1;
                        state <= S_HOLD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (io.out_ready) begin
                        cnt   <= '0;
                        state <= drain ? S_DRAIN : S_IDLE;
                    end
                end
                // swallow a late done from the timed-out request
                S_DRAIN: begin
                    if (gcd_done || cnt == CNT_LAST) begin
                        drain <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    drain <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_requester.sv
// Scoreboard bench for gcd_requester with a behavioural engine.
// The engine can be muted and a late done can be injected.
module tb_gcd_requester;

    logic        clk;
    logic        reset_n;
    logic [31:0] gcd_a;
    logic [31:0] gcd_b;
    logic        gcd_start;
    logic        gcd_done;
    logic [31:0] gcd_result;
    logic        busy;

    gcd_requester_if #(.WIDTH(32)) io ();

    gcd_requester #(.WIDTH(32), .TIMEOUT(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .io         (io),
        .gcd_a      (gcd_a),
        .gcd_b      (gcd_b),
        .gcd_start  (gcd_start),
        .gcd_done   (gcd_done),
        .gcd_result (gcd_result),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        mute;
    logic        inj;
    logic        e_run;
    logic        e_done;
    logic [31:0] e_a;
    logic [31:0] e_b;
    int          starts;

    // one Euclid remainder step per cycle
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_run  <= 1'b0;
            e_done <= 1'b0;
            e_a    <= '0;
            e_b    <= '0;
        end else begin
            e_done <= 1'b0;
            if (gcd_start) begin
                e_a   <= gcd_a;
                e_b   <= gcd_b;
                e_run <= 1'b1;
            end else if (e_run) begin
                if (e_b == 0) begin
                    e_run  <= 1'b0;
                    e_done <= !mute;
                end else begin
                    e_a <= e_b;
                    e_b <= e_a % e_b;
                end
            end
        end
    end

    assign gcd_done   = e_done | inj;
    assign gcd_result = e_done ? e_a : 32'd0;

    always @(posedge clk) if (gcd_start) starts <= starts + 1;

    int          n_cmp;
    int          n_bad;
    logic [32:0] sb[$];

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic send(logic [31:0] a, logic [31:0] b,
                        logic push, logic [32:0] exp);
        int n = 0;
        while (!io.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", io.in_ready, 1);
        io.in_valid = 1'b1;
        io.in_a     = a;
        io.in_b     = b;
        if (push) sb.push_back(exp);
        @(negedge clk);
        io.in_valid = 1'b0;
        chk("gcd_a_reg", gcd_a, a);
        chk("gcd_b_reg", gcd_b, b);
        chk("issue_start", gcd_start, b != 0);
        chk("bypass_valid", io.out_valid, b == 0);
    endtask

    task automatic recv(int stall);
        int          n = 0;
        logic [31:0] r0;
        logic        e0;
        logic [31:0] a0;
        logic [32:0] exp;
        while (!io.out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("out_valid_seen", io.out_valid, 1);
        if (io.out_valid) begin
            r0 = io.out_result;
            e0 = io.out_error;
            a0 = gcd_a;
            repeat (stall) begin
                @(negedge clk);
                chk("hold_valid", io.out_valid, 1);
                chk("hold_result", io.out_result, r0);
                chk("hold_error", io.out_error, e0);
                chk("hold_in_ready", io.in_ready, 0);
                chk("hold_busy", busy, 1);
                chk("hold_gcd_a", gcd_a, a0);
            end
            chk("sb_nonempty", sb.size() > 0, 1);
            exp = (sb.size() > 0) ? sb.pop_front() : 33'd0;
            io.in_valid  = 1'b0;
            io.out_ready = 1'b1;
            chk("result", io.out_result, exp[31:0]);
            chk("error", io.out_error, exp[32]);
            @(negedge clk);
            io.out_ready = 1'b0;
        end
    endtask

    task automatic chk_reset();
        chk("rst_in_ready", io.in_ready, 1);
        chk("rst_out_valid", io.out_valid, 0);
        chk("rst_out_result", io.out_result, 0);
        chk("rst_out_error", io.out_error, 0);
        chk("rst_gcd_start", gcd_start, 0);
        chk("rst_gcd_a", gcd_a, 0);
        chk("rst_gcd_b", gcd_b, 0);
        chk("rst_busy", busy, 0);
    endtask

    initial begin
        int s0;
        int n;
        n_cmp        = 0;
        n_bad        = 0;
        starts       = 0;
        mute         = 1'b0;
        inj          = 1'b0;
        reset_n      = 1'b0;
        io.in_valid  = 1'b0;
        io.in_a      = '0;
        io.in_b      = '0;
        io.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset();
        reset_n = 1'b1;
        @(negedge clk);

        s0 = starts;
        send(48, 18, 1, {1'b0, 32'd6});
        recv(2);
        chk("basic_starts", starts - s0, 1);

        s0 = starts;
        send(35, 0, 1, {1'b0, 32'd35});
        recv(0);
        send(0, 0, 1, {1'b0, 32'd0});
        recv(0);
        chk("bypass_starts", starts - s0, 0);

        send(0, 14, 1, {1'b0, 32'd14});
        recv(0);
        send(32'hFFFF_FFFF, 65535, 1, {1'b0, 32'd65535});
        recv(0);

        send(48, 18, 1, {1'b0, 32'd6});
        io.in_valid = 1'b1;
        io.in_a     = 999;
        io.in_b     = 3;
        recv(5);
        chk("bp_in_ready_after", io.in_ready, 1);

        mute = 1'b1;
        send(100, 7, 1, {1'b1, 32'd0});
        n = 0;
        while (!io.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_latency", n, 9);
        recv(0);
        n = 0;
        while (!io.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_len", n, 8);

        send(100, 7, 1, {1'b1, 32'd0});
        recv(0);
        repeat (3) @(negedge clk);
        chk("drain_in_ready", io.in_ready, 0);
        inj = 1'b1;
        @(negedge clk);
        inj = 1'b0;
        chk("late_done_exit", io.in_ready, 1);
        mute = 1'b0;

        send(1071, 462, 0, 33'd0);
        @(negedge clk);
        chk("mid_wait_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        chk_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("no_stale_resp", io.out_valid, 0);
        send(1071, 462, 1, {1'b0, 32'd21});
        recv(0);

        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
